lcd_capture_writer: RTL
=======================

// Module: lcd_capture_writer
// PURPOSE
//  Captures the Velo 500 mono STN panel bus (FLM/LP/CP, 4 px per CP) and writes it into the 1-bit framebuffer.
//  It is the write side of the framebuffer that VGA_timing scans out.
//  Asynchronous panel pins are synchronised into PixelClk; each nibble is queued, then serialised into 4 single-pixel writes.
// PARAMETERS
//  FB_H_SIZE    640  framebuffer pixels per row (multiple of 4)
//  FB_V_SIZE    240  framebuffer rows
//  ADDR_W       19   framebuffer address width
//  H_SKIP       0    leading pixels per line discarded (panel porch); multiple of 4
//  SYNC_STAGES  2    synchroniser flops on FLM/LP/CP/D (>=2)
//  FIFO_DEPTH   4    nibble FIFO entries (power of 2)
// PORTS
//  PixelClk       in   1       system clock; >= 8x CP frequency
//  nRST           in   1       asynchronous active-low reset
//  LCD_FLM        in   1       first-line marker, async
//  LCD_LP         in   1       line latch pulse, async; falling edge ends a line
//  LCD_CP         in   1       shift clock, async; falling edge = D valid
//  LCD_D          in   4       pixel nibble; D[3] = leftmost pixel, 1 = pixel on
//  fb_write_addr  out  ADDR_W  row*FB_H_SIZE + col
//  fb_write_data  out  1       pixel value
//  fb_write_en    out  1       one write per asserted cycle
//  frame_done     out  1       1-cycle pulse at each frame start after the first
//  overflow       out  1       sticky; FIFO full on push; cleared only by nRST
// BEHAVIOUR
//  Reset (async): all outputs 0; FIFO empty; x=0, y=0, line_base=0; FSM=WAIT_FRAME; synchronisers cleared.
//  Sync: FLM, LP, CP, D share one SYNC_STAGES chain; edges detected on synchronised copies (1 extra flop).
//  FSM WAIT_FRAME:
//   - ignore CP edges.
//   - LP fall with FLM=1 -> CAPTURE, x=0, y=0, line_base=0.
//  FSM CAPTURE:
//   - CP fall: if x>=H_SKIP && (x-H_SKIP)<FB_H_SIZE && y<FB_V_SIZE, push {line_base+x-H_SKIP, D}; x+=4, saturating at 12'hFFF.
//   - LP fall, FLM=0: x=0; y+=1, saturating at FB_V_SIZE; line_base+=FB_H_SIZE (no multiplier) while y<FB_V_SIZE.
//   - LP fall, FLM=1: x=0, y=0, line_base=0, frame_done=1 for one cycle.
//   - No return to WAIT_FRAME except by reset.
//  Same-cycle CP and LP edges: CP push uses pre-update x/y; the LP update then applies.
//  Rows >= FB_V_SIZE and cols outside the window: nibble dropped silently; not an overflow.
//  FIFO:
//   - Push when full: entry dropped, overflow<=1.
//   - Push and pop in the same cycle are allowed, including when full (the push is accepted).
//  Serializer (IDLE, PIX0..PIX3):
//   - IDLE pops when FIFO non-empty -> PIX0.
//   - PIXk drives fb_write_en=1, addr=base+k, data=D[3-k].
//   - PIX3 pops the next entry if available (back-to-back, no idle cycle), else -> IDLE.
//  Latency: FIFO empty, serializer IDLE -> first write SYNC_STAGES+3 clocks after the first PixelClk edge sampling CP low;
//   the 4 writes occupy consecutive cycles.
//  Outputs registered; fb_write_addr/data hold last value when fb_write_en=0.
//  Address arithmetic in ADDR_W bits, unsigned; FB_H_SIZE*FB_V_SIZE must be <= 2**ADDR_W (elaboration check).
// STRUCTURE
//  Shared package/include lcd_fb_pkg:
//   - FB_H_SIZE, FB_V_SIZE, ADDR_W (also used by VGA_timing).
//   - fifo entry layout {addr[ADDR_W-1:0], nib[3:0]}.
//  Sub-module nibble_fifo: synchronous FIFO, width ADDR_W+4, depth FIFO_DEPTH, full/empty flags, async active-low reset.
//  Top: synchronisers + edge detect, capture FSM with x/y/line_base counters, serializer FSM.
// TESTING
//  1 Reset, then CP toggling with FLM=0 -> no fb_write_en, frame_done=0, overflow=0.
//  2 FLM=1+LP pulse, then one CP with D=4'b1010 -> writes addr 0,1,2,3, data 1,0,1,0 on consecutive cycles,
//    first at SYNC_STAGES+3 clocks.
//  3 Frame start, 5 LP, then 160 CP with D=4'hF, then LP -> 640 writes, addr 3200..3839, all data 1;
//    the next line starts at 3840.
//  4 H_SKIP=8: first 2 nibbles dropped; third nibble (D=4'h8) -> addr 0 data 1, addr 1..3 data 0.
//  5 CP falls every 2 clocks, FIFO_DEPTH=4 -> overflow=1 once FIFO is full; accepted nibbles written in order;
//    nRST pulse mid-PIX2 -> outputs 0 immediately, FIFO empty, WAIT_FRAME.
//  6 Drive 245 lines, then FLM=1+LP -> no writes for rows 240..244;
//    frame_done 1-cycle pulse; next CP writes addr 0.

Source files
------------

// File: rtl/lcd_fb_pkg.sv
// Framebuffer geometry shared by the panel capture side and the VGA scan-out side,
// plus the layout of one queued nibble.
package lcd_fb_pkg;

   localparam int FB_H_SIZE = 640;
   localparam int FB_V_SIZE = 240;
   localparam int ADDR_W    = 19;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        nib;
   } fifo_entry_t;

   typedef enum logic {
      CAP_WAIT_FRAME,
      CAP_CAPTURE
   } cap_state_t;

   typedef enum logic [2:0] {
      SER_IDLE,
      SER_PIX0,
      SER_PIX1,
      SER_PIX2,
      SER_PIX3
   } ser_state_t;

endpackage

// File: rtl/lcd_capture_writer_fifo.sv
// Small synchronous FIFO holding captured nibbles and their base addresses.
module nibble_fifo #(
   parameter int WIDTH = 23,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   // A push into a full FIFO still lands when the same cycle frees a slot.
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lcd_capture_writer.sv
// Captures the mono STN panel bus (FLM/LP/CP, 4 px per CP) into the 1-bit framebuffer,
// one pixel write per cycle.
module lcd_capture_writer
   import lcd_fb_pkg::*;
#(
   parameter int H_SKIP      = 0,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              PixelClk,
   input  logic              nRST,
   input  logic              LCD_FLM,
   input  logic              LCD_LP,
   input  logic              LCD_CP,
   input  logic [3:0]        LCD_D,
   output logic [ADDR_W-1:0] fb_write_addr,
   output logic              fb_write_data,
   output logic              fb_write_en,
   output logic              frame_done,
   output logic              overflow
);

   localparam int Y_W = $clog2(FB_V_SIZE + 1);

   if (FB_H_SIZE * FB_V_SIZE > 2 ** ADDR_W) begin : g_size_check
      $error("framebuffer does not fit in ADDR_W address bits");
   end

   logic [6:0]        sync_pipe [SYNC_STAGES];
   logic [6:0]        pins;
   logic [1:0]        edge_prev;
   logic              flm, cp_fall, lp_fall, in_window;
   logic [3:0]        nib;
   cap_state_t        cap_state;
   ser_state_t        ser_state;
   logic [11:0]       x;
   logic [Y_W-1:0]    y;
   logic [ADDR_W-1:0] line_base;
   logic              push;
   fifo_entry_t       push_entry;
   fifo_entry_t       head;
   fifo_entry_t       cur;
   logic              pop, full, empty, pix_active;
   logic [1:0]        pix_idx;

   // FLM/LP/CP/D travel through one chain so D stays aligned with its CP edge.
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
         edge_prev <= '0;
      end else begin
         sync_pipe[0] <= {LCD_FLM, LCD_LP, LCD_CP, LCD_D};
         for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
         edge_prev <= sync_pipe[SYNC_STAGES-1][5:4];
      end
   end

   assign pins    = sync_pipe[SYNC_STAGES-1];
   assign flm     = pins[6];
   assign nib     = pins[3:0];
   assign lp_fall = edge_prev[1] & ~pins[5];
   assign cp_fall = edge_prev[0] & ~pins[4];

   assign in_window = (int'(x) >= H_SKIP) && (int'(x) - H_SKIP < FB_H_SIZE)
                      && (int'(y) < FB_V_SIZE);

   // CP handling precedes LP so a coincident LP edge overrides the x/y update.
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         cap_state  <= CAP_WAIT_FRAME;
         x          <= '0;
         y          <= '0;
         line_base  <= '0;
         frame_done <= 1'b0;
         push       <= 1'b0;
         push_entry <= '0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         push       <= 1'b0;
         if (push && full && !pop) overflow <= 1'b1;
         case (cap_state)
            CAP_WAIT_FRAME: begin
               if (lp_fall && flm) begin
                  cap_state <= CAP_CAPTURE;
                  x         <= '0;
                  y         <= '0;
                  line_base <= '0;
               end
            end
            CAP_CAPTURE: begin
               if (cp_fall) begin
                  if (in_window) begin
                     push            <= 1'b1;
                     push_entry.addr <= line_base + ADDR_W'(x) - ADDR_W'(H_SKIP);
                     push_entry.nib  <= nib;
                  end
                  x <= (x > 12'hFFB) ? 12'hFFF : x + 12'd4;
               end
               if (lp_fall) begin
                  x <= '0;
                  if (flm) begin
                     y          <= '0;
                     line_base  <= '0;
                     frame_done <= 1'b1;
                  end else if (int'(y) < FB_V_SIZE) begin
                     y         <= y + 1'b1;
                     line_base <= line_base + ADDR_W'(FB_H_SIZE);
                  end
               end
            end
            default: cap_state <= CAP_WAIT_FRAME;
         endcase
      end
   end

   nibble_fifo #(
      .WIDTH (ADDR_W + 4),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (PixelClk),
      .rst_n     (nRST),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   assign pop = !empty && (ser_state == SER_IDLE || ser_state == SER_PIX3);

   always_comb begin
      pix_active = 1'b1;
      pix_idx    = 2'd0;
      case (ser_state)
         SER_PIX0: pix_idx = 2'd0;
         SER_PIX1: pix_idx = 2'd1;
         SER_PIX2: pix_idx = 2'd2;
         SER_PIX3: pix_idx = 2'd3;
         default:  pix_active = 1'b0;
      endcase
   end

   // Write outputs are registered from the serializer state, one pixel per cycle.
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         ser_state     <= SER_IDLE;
         cur           <= '0;
         fb_write_en   <= 1'b0;
         fb_write_addr <= '0;
         fb_write_data <= 1'b0;
      end else begin
         fb_write_en <= pix_active;
         if (pix_active) begin
            fb_write_addr <= cur.addr + ADDR_W'(pix_idx);
            fb_write_data <= cur.nib[2'd3 - pix_idx];
         end
         case (ser_state)
            SER_PIX0: ser_state <= SER_PIX1;
            SER_PIX1: ser_state <= SER_PIX2;
            SER_PIX2: ser_state <= SER_PIX3;
            SER_IDLE, SER_PIX3: begin
               if (!empty) begin
                  cur       <= head;
                  ser_state <= SER_PIX0;
               end else begin
                  ser_state <= SER_IDLE;
               end
            end
            default: ser_state <= SER_IDLE;
         endcase
      end
   end

endmodule
